alu_operand_serializer: RTL and testbench

- Sits between the byte-wide memory/immediate interface and the ALU's serial external operand/result lanes.
- Collects a 1- or 2-byte operand over a valid/ready byte handshake.
- Streams the operand LSB-first, NSHIFT bits per cycle, into the ALU's data_in lane.
- Simultaneously captures the ALU's data_out lane into the same shift register, then optionally drains the result back out as bytes for memory write-back.

---
 rtl/alu_operand_serializer.sv | 163 ++++++++++++++++
 tb/tb_alu_operand_serializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_serializer.sv
// Byte-to-serial operand bridge for the ALU's external lanes: fills, shifts and drains results.
// Optional byte prefetch skid register enabled by defining SERIALIZER_PREFETCH_EN.
module alu_operand_serializer #(
  parameter int unsigned REG_BITS = 8,
  parameter int unsigned NSHIFT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                start_pair,
  input  logic                start_writeback,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_BITS-1:0] in_data,
  output logic                operand_ready,
  input  logic                advance,
  input  logic                alu_op_done,
  output logic [NSHIFT-1:0]   to_alu,
  input  logic [NSHIFT-1:0]   from_alu,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_BITS-1:0] out_data,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StFill, StShift, StDrain} state_e;

  state_e                state_q, state_d;
  logic [2*REG_BITS-1:0] sr_q, sr_d;
  logic                  bcnt_q, bcnt_d;
  logic                  pair_q, pair_d;
  logic                  wb_q, wb_d;
  logic                  fill_take;
  logic [REG_BITS-1:0]   fill_byte;
`ifdef SERIALIZER_PREFETCH_EN
  logic [REG_BITS-1:0]   pf_q, pf_d;
  logic                  pf_v_q, pf_v_d;
`endif

  // Single-byte operands clear the upper byte so the result lands cleanly in the low byte.
  function automatic logic [2*REG_BITS-1:0] load_byte(input logic [2*REG_BITS-1:0] cur,
                                                      input logic                  sel,
                                                      input logic                  is_pair,
                                                      input logic [REG_BITS-1:0]   b);
    logic [2*REG_BITS-1:0] r;
    r = cur;
    if (!sel) begin
      r[REG_BITS-1:0] = b;
      if (!is_pair) r[2*REG_BITS-1:REG_BITS] = '0;
    end else begin
      r[2*REG_BITS-1:REG_BITS] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bcnt_d        = bcnt_q;
    pair_d        = pair_q;
    wb_d          = wb_q;
    in_ready      = 1'b0;
    operand_ready = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    to_alu        = '0;
    fill_take     = 1'b0;
    fill_byte     = in_data;
    busy          = (state_q != StIdle);
`ifdef SERIALIZER_PREFETCH_EN
    pf_d          = pf_q;
    pf_v_d        = pf_v_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pair_d  = start_pair;
          wb_d    = start_writeback;
          bcnt_d  = 1'b0;
          state_d = StFill;
        end
      end
      StFill: begin
        in_ready  = 1'b1;
        fill_take = in_valid;
`ifdef SERIALIZER_PREFETCH_EN
        // A prefetched byte occupies the entry cycle as byte 0, so no handshake then.
        if (pf_v_q) begin
          in_ready  = 1'b0;
          fill_take = 1'b1;
          fill_byte = pf_q;
          pf_v_d    = 1'b0;
        end
`endif
        if (fill_take) begin
          sr_d   = load_byte(sr_q, bcnt_q, pair_q, fill_byte);
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == pair_q) begin
            bcnt_d  = 1'b0;
            state_d = StShift;
          end
        end
      end
      StShift: begin
        operand_ready = 1'b1;
        to_alu        = sr_q[NSHIFT-1:0];
        if (advance) begin
          if (pair_q) sr_d = {from_alu, sr_q[2*REG_BITS-1:NSHIFT]};
          else        sr_d[REG_BITS-1:0] = {from_alu, sr_q[REG_BITS-1:NSHIFT]};
          if (alu_op_done) begin
            bcnt_d  = 1'b0;
            state_d = wb_q ? StDrain : StIdle;
          end
        end
      end
      StDrain: begin
        out_valid = 1'b1;
        out_data  = bcnt_q ? sr_q[2*REG_BITS-1:REG_BITS] : sr_q[REG_BITS-1:0];
        if (out_ready) begin
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == pair_q) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef SERIALIZER_PREFETCH_EN
    if ((state_q == StShift || state_q == StDrain) && !pf_v_q) begin
      in_ready = 1'b1;
      if (in_valid) begin
        pf_d   = in_data;
        pf_v_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bcnt_q  <= 1'b0;
      pair_q  <= 1'b0;
      wb_q    <= 1'b0;
`ifdef SERIALIZER_PREFETCH_EN
      pf_q    <= '0;
      pf_v_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      pair_q  <= pair_d;
      wb_q    <= wb_d;
`ifdef SERIALIZER_PREFETCH_EN
      pf_q    <= pf_d;
      pf_v_q  <= pf_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_operand_serializer.sv
// Directed self-checking bench for alu_operand_serializer (REG_BITS=8, NSHIFT=2).
module tb_alu_operand_serializer;

`ifdef SERIALIZER_PREFETCH_EN
  localparam bit Pf = 1'b1;
`else
  localparam bit Pf = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start_pair, start_writeback;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       operand_ready, advance, alu_op_done;
  logic [1:0] to_alu, from_alu, fa;
  logic       loop;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Loopback models an ALU that returns its operand unchanged.
  assign from_alu = loop ? to_alu : fa;

  alu_operand_serializer #(.REG_BITS(8), .NSHIFT(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_pair      (start_pair),
    .start_writeback (start_writeback),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .operand_ready   (operand_ready),
    .advance         (advance),
    .alu_op_done     (alu_op_done),
    .to_alu          (to_alu),
    .from_alu        (from_alu),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic pair, input logic wb);
    start = 1'b1; start_pair = pair; start_writeback = wb;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = b;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    step();
    in_valid = 1'b0; in_data = 8'hEE;
  endtask

  // Advance every cycle in loopback, op_done on the last step; checks the lane sequence.
  task automatic shift_loop(input int n, input logic [15:0] exp_bits, input string tag);
    loop = 1'b1;
    for (int i = 0; i < n; i++) begin
      advance = 1'b1; alu_op_done = (i == n - 1);
      #1;
      check(tag, to_alu, exp_bits[2*i +: 2]);
      step();
    end
    advance = 1'b0; alu_op_done = 1'b0;
  endtask

  initial begin
    logic [1:0] fa_tab  [4];
    logic [1:0] exp3    [4];
    int k;
    fa_tab = '{2'd3, 2'd2, 2'd1, 2'd0};
    exp3   = '{2'd1, 2'd1, 2'd2, 2'd2};
    reset = 1'b1; start = 1'b0; start_pair = 1'b0; start_writeback = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; advance = 1'b0; alu_op_done = 1'b0;
    fa = 2'd0; loop = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_to_alu", to_alu, 0);

    // 1: reset in the middle of a pair fill
    do_start(1'b1, 1'b1);
    check("fill_in_ready", in_ready, 1);
    check("fill_busy", busy, 1);
    send_byte(8'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sr", dut.sr_q, 0);

    // 2: pair passthrough with write-back; 0x1234 LSB-first in 2-bit groups
    do_start(1'b1, 1'b1);
    send_byte(8'h34);
    check("p_no_opready", operand_ready, 0);
    send_byte(8'h12);
    check("p_opready", operand_ready, 1);
    check("p_shift_in_ready", in_ready, Pf);
    shift_loop(8, 16'b00_01_00_10_00_11_01_00, "p_to_alu");
    check("p_dr_valid", out_valid, 1);
    check("p_dr_lo", out_data, 8'h34);
    out_ready = 1'b1;
    step();
    check("p_dr_hi", out_data, 8'h12);
    check("p_dr_valid2", out_valid, 1);
    step();
    out_ready = 1'b0;
    #1;
    check("p_end_valid", out_valid, 0);
    check("p_end_busy", busy, 0);

    // 3: single byte, stalled advance, op_done pulses during stalls are ignored
    do_start(1'b0, 1'b1);
    send_byte(8'hA5);
    loop = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        advance = 1'b1; fa = fa_tab[k]; alu_op_done = (k == 3);
        #1;
        check("s_to_alu", to_alu, exp3[k]);
        k++;
      end else begin
        advance = 1'b0; alu_op_done = 1'b1;
        #1;
        if (c < 7) check("s_stall_opready", operand_ready, 1);
        else       check("s_drain_valid", out_valid, 1);
      end
      step();
    end
    advance = 1'b0; alu_op_done = 1'b0;
    #1;
    check("s_result", out_data, 8'h1B);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("s_one_byte_only", out_valid, 0);
    check("s_idle", busy, 0);

    // 4: no write-back returns straight to idle
    do_start(1'b0, 1'b0);
    send_byte(8'h0F);
    check("nw_no_valid", out_valid, 0);
    shift_loop(4, 16'h00F0 >> 4, "nw_to_alu");
    check("nw_idle", busy, 0);
    check("nw_no_valid2", out_valid, 0);
    check("nw_opready", operand_ready, 0);

    // 5: input gaps, output backpressure, start ignored while busy
    do_start(1'b1, 1'b1);
    send_byte(8'hCD);
    in_valid = 1'b0; in_data = 8'h99;
    step();
    check("bp_gap_ready", in_ready, 1);
    send_byte(8'hAB);
    shift_loop(8, 16'hABCD, "bp_to_alu");
    start = 1'b1; start_pair = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 8'hCD);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_lo", out_data, 8'hCD);
    step();
    check("bp_hi", out_data, 8'hAB);
    step();
    out_ready = 1'b0;
    #1;
    check("bp_end_busy", busy, 0);
    check("bp_end_valid", out_valid, 0);

`ifdef SERIALIZER_PREFETCH_EN
    // 6: byte offered during SHIFT becomes the next operand's low byte
    do_start(1'b1, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("pf_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("pf_full", in_ready, 0);
    shift_loop(8, 16'h0201, "pf_to_alu");
    do_start(1'b1, 1'b0);
    check("pf_entry_no_ready", in_ready, 0);
    step();
    send_byte(8'h11);
    check("pf_opready", operand_ready, 1);
    check("pf_low_bits", to_alu, 2'd3);
    check("pf_sr", dut.sr_q, 16'h1177);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
